// File: rtl/wb_pkg.sv
// Shared types and helpers for the white-box column diffusion datapath.
package wb_pkg;

  localparam int BYTE_W = 8;
  localparam int MAX_NB = 16;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMB = 2'd2,
    OUT  = 2'd3
  } state_t;

  // XOR of the first nb bytes of a column; the column is zero-extended to MAX_NB bytes.
  function automatic byte_t col_xor(input logic [BYTE_W*MAX_NB-1:0] col, input int nb);
    byte_t acc;
    acc = '0;
    for (int i = 0; i < MAX_NB; i++) begin
      if (i < nb) acc ^= col[BYTE_W*i +: BYTE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/wb_col_mix_seq.sv
// Byte-serial column diffusion: each byte goes through the external D1 multiplier,
// then o_j = D1(b_j) ^ b_j ^ XOR(all b). Build option WB_MIX_MASK_EN adds an output mask byte.
//
// state | meaning
// IDLE  | waiting for a column, in_ready high
// MUL   | presenting b[cnt] on mul_in, capturing mul_out into prod[cnt]
// COMB  | combining products with raw bytes into out_data
// OUT   | holding out_data with out_valid until out_ready
module wb_col_mix_seq
  import wb_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8*NB-1:0]   in_data,
  output logic [7:0]        mul_in,
  input  logic [7:0]        mul_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [8*NB-1:0]   out_data,
  output logic              busy
`ifdef WB_MIX_MASK_EN
  ,
  input  logic [7:0]        in_mask
`endif
);

  localparam int CW = (NB > 2) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  state_t          state;
  byte_t           b    [NB];
  byte_t           prod [NB];
  logic [CW-1:0]   cnt;
`ifdef WB_MIX_MASK_EN
  byte_t           mask_q;
`endif

  logic [BYTE_W*MAX_NB-1:0] b_ext;
  byte_t                    p_all;
  logic [8*NB-1:0]          mix_col;

  always_comb begin
    b_ext   = '0;
    mix_col = '0;
    for (int j = 0; j < NB; j++) b_ext[BYTE_W*j +: BYTE_W] = b[j];
    p_all = col_xor(b_ext, NB);
    for (int j = 0; j < NB; j++) begin
`ifdef WB_MIX_MASK_EN
      mix_col[BYTE_W*j +: BYTE_W] = prod[j] ^ b[j] ^ p_all ^ mask_q;
`else
      mix_col[BYTE_W*j +: BYTE_W] = prod[j] ^ b[j] ^ p_all;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      mul_in    <= '0;
      cnt       <= '0;
      for (int j = 0; j < NB; j++) begin
        b[j]    <= '0;
        prod[j] <= '0;
      end
`ifdef WB_MIX_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int j = 0; j < NB; j++) b[j] <= in_data[BYTE_W*j +: BYTE_W];
`ifdef WB_MIX_MASK_EN
            mask_q   <= in_mask;
`endif
            cnt      <= '0;
            mul_in   <= in_data[BYTE_W-1:0];
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          prod[cnt] <= mul_out;
          cnt       <= cnt + CW'(1);
          // mul_in is loaded one cycle ahead so it stays a registered function of state
          if (cnt == CNT_LAST) begin
            mul_in <= '0;
            state  <= COMB;
          end else begin
            mul_in <= b[cnt + CW'(1)];
          end
        end
        COMB: begin
          out_data  <= mix_col;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_col_mix_seq.sv
// Self-checking bench for wb_col_mix_seq; closes the loop with a behavioural D1 multiplier.
module tb_wb_col_mix_seq;

  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [8*NB-1:0] in_data;
  logic [7:0]      mul_in;
  logic [7:0]      mul_out;
  logic            out_valid;
  logic            out_ready;
  logic [8*NB-1:0] out_data;
  logic            busy;
  logic [7:0]      in_mask;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // GF(2^8) multiply by 0xD1, AES reduction polynomial 0x11B
  function automatic logic [7:0] d1(input logic [7:0] a);
    logic [7:0] acc, x;
    logic [7:0] k;
    acc = '0;
    x   = a;
    k   = 8'hD1;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return acc;
  endfunction

  assign mul_out = d1(mul_in);

  wb_col_mix_seq #(.NB(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mul_in    (mul_in),
    .mul_out   (mul_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef WB_MIX_MASK_EN
    ,
    .in_mask   (in_mask)
`endif
  );

  // o_j = D1(b_j) xor every other byte of the column, then the output mask
  function automatic logic [8*NB-1:0] model(input logic [8*NB-1:0] col, input logic [7:0] m);
    logic [8*NB-1:0] res;
    logic [7:0]      acc;
    logic [7:0]      mk;
`ifdef WB_MIX_MASK_EN
    mk = m;
`else
    mk = 8'h00;
`endif
    res = '0;
    for (int j = 0; j < NB; j++) begin
      acc = d1(col[8*j +: 8]);
      for (int k = 0; k < NB; k++)
        if (k != j) acc ^= col[8*k +: 8];
      res[8*j +: 8] = acc ^ mk;
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [8*NB-1:0] rand_col();
    logic [8*NB-1:0] c;
    for (int j = 0; j < NB; j++) c[8*j +: 8] = 8'($urandom_range(0, 255));
    return c;
  endfunction

  // Send one column with out_ready high; check latency, mul_in sequence and result.
  task automatic run_col(input string tag, input logic [8*NB-1:0] col, input logic [7:0] m);
    int cyc;
    logic [7:0] seq [NB];
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = col;
    in_mask  = m;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!out_valid && cyc < 40) begin
      if (cyc <= NB) seq[cyc-1] = mul_in;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(NB + 2));
    check({tag, "_data"}, 64'(out_data), 64'(model(col, m)));
    for (int i = 0; i < NB; i++)
      check({tag, "_mul_in"}, 64'(seq[i]), 64'(col[8*i +: 8]));
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [8*NB-1:0] exp_q [$];
    logic [8*NB-1:0] held;
    int cyc, n_acc, n_out, last_acc;
    bit acc_pending;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; in_mask = 8'h00;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_mul_in", 64'(mul_in), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_col("one", 32'h0000_0001, 8'h00);
    check("one_const", 64'(out_data), 64'h0101_01D1);
    run_col("ones", 32'hFFFF_FFFF, 8'h00);
    check("ones_const", 64'(out_data), 64'hB3B3_B3B3);

    // back-pressure in OUT
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234_5678; in_mask = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_latency", 64'(cyc), 64'(NB + 2));
    held = out_data;
    check("bp_data", 64'(held), 64'(model(32'h1234_5678, 8'h00)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_data_hold", 64'(out_data), 64'(held));
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    check("bp_data_kept", 64'(out_data), 64'(held));

    // async reset during the 3rd MUL cycle
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_mul_in", 64'(mul_in), 64'hFF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_mul_in", 64'(mul_in), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NB + 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", 64'(out_valid), 64'd0);
    end
    run_col("after_rst", 32'h0000_0001, 8'h00);
    check("after_rst_const", 64'(out_data), 64'h0101_01D1);

`ifdef WB_MIX_MASK_EN
    run_col("mask", 32'h0000_0001, 8'h5A);
    check("mask_const", 64'(out_data), 64'h5B5B_5B8B);
`endif

    // random columns, in_valid held high
    in_valid = 1'b1; in_data = rand_col(); in_mask = 8'($urandom_range(0, 255));
    n_acc = 0; n_out = 0; last_acc = 0; cyc = 0; acc_pending = 1'b0;
    while (n_out < 6 && cyc < 200) begin
      if (out_valid) begin
        check("rnd_expected_out", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("rnd_data", 64'(out_data), 64'(exp_q.pop_front()));
        n_out++;
      end
      if (in_valid && in_ready) begin
        if (n_acc > 0) check("rnd_spacing", 64'(cyc - last_acc), 64'(NB + 3));
        last_acc = cyc;
        exp_q.push_back(model(in_data, in_mask));
        n_acc++;
        acc_pending = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (acc_pending) begin
        acc_pending = 1'b0;
        in_data = rand_col();
        in_mask = 8'($urandom_range(0, 255));
        if (n_acc == 6) in_valid = 1'b0;
      end
    end
    check("rnd_out_count", 64'(n_out), 64'd6);
    check("rnd_acc_count", 64'(n_acc), 64'd6);
    check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
